tinyvga_rx_monitor: RTL and testbench

Receive-side checker for the TinyVGA PMOD bus and the audio PWM pin that the demo generators drive. It sits on the `uo_out`/`uio_out[7]` nets in loopback benches and in the FPGA self-test build. It recovers sync timing from the bus and computes a per-frame pixel signature and an audio PWM duty count. It then reports these once per frame so that frame-exact checks need no pixel dumps.

---
 rtl/tinyvga_rx_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_tinyvga_rx_monitor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyvga_rx_monitor.sv
// rtl/tinyvga_rx_monitor.sv - TinyVGA PMOD bus / audio PWM receive monitor with per-frame signatures
module tinyvga_rx_monitor #(
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 36,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    input  logic        audio_in,
    output logic        frame_done,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [10:0] hsync_width,
    output logic [9:0]  frame_lines,
    output logic [18:0] active_pixels,
    output logic [15:0] frame_sig,
    output logic [19:0] audio_ones,
    output logic [7:0]  frame_count
);

    localparam logic [11:0] H_LO   = 12'(H_START);
    localparam logic [11:0] H_HI   = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO   = 11'(V_START);
    localparam logic [10:0] V_HI   = 11'(V_START + V_ACTIVE);
    localparam logic [10:0] H_MAX  = 11'h7FF;
    localparam logic [9:0]  V_MAX  = 10'h3FF;
    localparam logic [19:0] A_MAX  = 20'hFFFFF;
    // Idle bus value: both syncs high, colour black
    localparam logic [7:0]  BUS_IDLE = 8'h88;

    // Sampled bus and edge history
    logic [7:0]  vq_q;
    logic        aq_q;
    logic        hs_prev_q;
    logic        vs_prev_q;

    // Timing counters
    logic [10:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [10:0] hwcnt_q, hwcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;

    // Per-frame accumulators
    logic [15:0] sig_q, sig_d;
    logic [18:0] apix_q, apix_d;
    logic [19:0] aones_q, aones_d;

    // Reported results
    logic        frame_done_q;
    logic        locked_q;
    logic [10:0] line_len_q;
    logic [10:0] prev_line_len_q;
    logic [10:0] hsync_width_q;
    logic [9:0]  frame_lines_q;
    logic [18:0] active_pixels_q;
    logic [15:0] frame_sig_q;
    logic [19:0] audio_ones_q;
    logic [7:0]  frame_count_q;

    logic        hs, vs;
    logic [5:0]  pix;
    logic        hfall, hrise, vfall;
    logic        h_win, v_win, in_win;

    assign hs    = vq_q[7];
    assign vs    = vq_q[3];
    assign pix   = {vq_q[0], vq_q[4], vq_q[1], vq_q[5], vq_q[2], vq_q[6]};
    assign hfall = hs_prev_q & ~hs;
    assign hrise = ~hs_prev_q & hs;
    assign vfall = vs_prev_q & ~vs;

    // Next-state for counters, window decode and accumulators
    always_comb begin
        hcnt_inc = (hcnt_q == H_MAX) ? hcnt_q : hcnt_q + 11'd1;
        hcnt_d   = hfall ? 11'd0 : hcnt_inc;

        // The falling-edge sample is itself low, so the count restarts at 1
        hwcnt_d = hwcnt_q;
        if (hfall) begin
            hwcnt_d = 11'd1;
        end else if (!hs && hwcnt_q != H_MAX) begin
            hwcnt_d = hwcnt_q + 11'd1;
        end

        vcnt_d = vcnt_q;
        if (vfall) begin
            vcnt_d = 10'd0;
        end else if (hfall && vcnt_q != V_MAX) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        h_win  = ({1'b0, hcnt_d} >= H_LO) && ({1'b0, hcnt_d} < H_HI);
        v_win  = ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
        in_win = h_win && v_win;

        sig_d  = sig_q;
        apix_d = apix_q;
        if (in_win) begin
            sig_d  = {sig_q[14:0], sig_q[15]} ^ {10'b0, pix};
            apix_d = apix_q + 19'd1;
        end

        aones_d = aones_q;
        if (aq_q && aones_q != A_MAX) begin
            aones_d = aones_q + 20'd1;
        end
    end

    // Input register; vq idles with syncs high so reset release is not seen as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq_q      <= BUS_IDLE;
            aq_q      <= 1'b0;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vq_q      <= vga_in;
            aq_q      <= audio_in;
            hs_prev_q <= hs;
            vs_prev_q <= vs;
        end
    end

    // Horizontal/vertical counters and hsync measurements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            hwcnt_q       <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            hsync_width_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            hwcnt_q <= hwcnt_d;
            vcnt_q  <= vcnt_d;
            if (hfall) begin
                line_len_q <= hcnt_inc;
            end
            if (hrise) begin
                hsync_width_q <= hwcnt_q;
            end
        end
    end

    // Frame accumulation and result latch; the vfall sample closes the old frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q           <= '0;
            apix_q          <= '0;
            aones_q         <= '0;
            frame_done_q    <= 1'b0;
            frame_lines_q   <= '0;
            frame_sig_q     <= '0;
            active_pixels_q <= '0;
            audio_ones_q    <= '0;
            frame_count_q   <= '0;
        end else begin
            frame_done_q <= vfall;
            if (vfall) begin
                frame_lines_q   <= vcnt_q;
                frame_sig_q     <= sig_d;
                active_pixels_q <= apix_d;
                audio_ones_q    <= aones_d;
                frame_count_q   <= frame_count_q + 8'd1;
                sig_q           <= '0;
                apix_q          <= '0;
                aones_q         <= '0;
            end else begin
                sig_q   <= sig_d;
                apix_q  <= apix_d;
                aones_q <= aones_d;
            end
        end
    end

    // Lock: frame geometry repeats; a saturated hcnt means hsync is gone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q        <= 1'b0;
            prev_line_len_q <= '0;
        end else begin
            if (vfall) begin
                prev_line_len_q <= line_len_q;
            end
            if (hcnt_q == H_MAX) begin
                locked_q <= 1'b0;
            end else if (vfall) begin
                locked_q <= (vcnt_q == frame_lines_q) &&
                            (line_len_q == prev_line_len_q) &&
                            (vcnt_q != 10'd0);
            end
        end
    end

    assign frame_done    = frame_done_q;
    assign locked        = locked_q;
    assign line_len      = line_len_q;
    assign hsync_width   = hsync_width_q;
    assign frame_lines   = frame_lines_q;
    assign active_pixels = active_pixels_q;
    assign frame_sig     = frame_sig_q;
    assign audio_ones    = audio_ones_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_tinyvga_rx_monitor.sv
// tb/tb_tinyvga_rx_monitor.sv - table-driven bench for tinyvga_rx_monitor on a scaled-down raster
module tb_tinyvga_rx_monitor;

    // Scaled raster: 40-clock lines, 6-clock hsync, 24x20 window at (10,4).
    // 480 window pixels keeps the same rotation phase (mod 16) as 640x480.
    localparam int LINE = 40;
    localparam int HSW  = 6;
    localparam int HS   = 10;
    localparam int HA   = 24;
    localparam int VS   = 4;
    localparam int VA   = 20;
    localparam int XV   = 20;   // vsync falls mid-line, never on an hsync fall
    localparam int NV   = 11;
    localparam int FD_BUDGET = 2500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_in;
    logic        audio_in;
    logic        frame_done;
    logic        locked;
    logic [10:0] line_len;
    logic [10:0] hsync_width;
    logic [9:0]  frame_lines;
    logic [18:0] active_pixels;
    logic [15:0] frame_sig;
    logic [19:0] audio_ones;
    logic [7:0]  frame_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         nl;
        int         aud;     // 0 low, 1 high, 2 toggling (high on odd samples)
        int         p0x, p0l;
        logic [5:0] p0v;
        int         p1x, p1l;
        logic [5:0] p1v;
        bit         border;  // 0x3F on every sample outside the window
        int         e_lines;
        int         e_apix;
        logic [15:0] e_sig;
        int         e_aud;
        bit         e_lock;
        int         e_fc;
    } vec_t;

    vec_t tbl [NV];

    tinyvga_rx_monitor #(
        .H_START (HS),
        .H_ACTIVE(HA),
        .V_START (VS),
        .V_ACTIVE(VA)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_in       (vga_in),
        .audio_in     (audio_in),
        .frame_done   (frame_done),
        .locked       (locked),
        .line_len     (line_len),
        .hsync_width  (hsync_width),
        .frame_lines  (frame_lines),
        .active_pixels(active_pixels),
        .frame_sig    (frame_sig),
        .audio_ones   (audio_ones),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int nl, int aud, int p0x, int p0l, logic [5:0] p0v,
                                int p1x, int p1l, logic [5:0] p1v, bit border,
                                int e_lines, int e_apix, logic [15:0] e_sig,
                                int e_aud, bit e_lock, int e_fc);
        vec_t v;
        v.nl = nl; v.aud = aud;
        v.p0x = p0x; v.p0l = p0l; v.p0v = p0v;
        v.p1x = p1x; v.p1l = p1l; v.p1v = p1v;
        v.border = border;
        v.e_lines = e_lines; v.e_apix = e_apix; v.e_sig = e_sig;
        v.e_aud = e_aud; v.e_lock = e_lock; v.e_fc = e_fc;
        return v;
    endfunction

    function automatic logic [7:0] encode(bit hs, bit vs, logic [5:0] p);
        logic [7:0] b;
        b[7] = hs;   b[3] = vs;
        b[0] = p[5]; b[4] = p[4];
        b[1] = p[3]; b[5] = p[2];
        b[2] = p[1]; b[6] = p[0];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic a);
        @(posedge clk);
        #1;
        vga_in   = b;
        audio_in = a;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < FD_BUDGET; c++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One frame starting at its vsync-fall sample; t=0 sits at x=XV of line 0
    task automatic gen_frame(input vec_t v);
        for (int t = 0; t < v.nl * LINE; t++) begin
            int x, l;
            bit hs, vs, a, inw;
            logic [5:0] p;
            x   = (t + XV) % LINE;
            l   = (t + XV) / LINE;
            hs  = (x >= HSW);
            vs  = !(t < 2 * LINE);
            inw = (x >= HS) && (x < HS + HA) && (l >= VS) && (l < VS + VA);
            p   = (v.border && !inw) ? 6'h3F : 6'h00;
            if (x == v.p0x && l == v.p0l) p = v.p0v;
            if (x == v.p1x && l == v.p1l) p = v.p1v;
            a = (v.aud == 1) || (v.aud == 2 && (t % 2) == 1);
            drive(encode(hs, vs, p), a);
        end
    endtask

    task automatic check_report(input string tag, input vec_t v);
        check({tag, ".frame_lines"},   32'(frame_lines),   32'(v.e_lines));
        check({tag, ".active_pixels"}, 32'(active_pixels), 32'(v.e_apix));
        check({tag, ".frame_sig"},     32'(frame_sig),     32'(v.e_sig));
        check({tag, ".audio_ones"},    32'(audio_ones),    32'(v.e_aud));
        check({tag, ".locked"},        32'(locked),        32'(v.e_lock));
        check({tag, ".frame_count"},   32'(frame_count),   32'(v.e_fc));
        check({tag, ".line_len"},      32'(line_len),      32'(LINE));
        check({tag, ".hsync_width"},   32'(hsync_width),   32'(HSW));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int fd_seen;
        vec_t tail;

        //            nl aud  p0x p0l p0v    p1x p1l p1v   brd lines apix sig      aud  lk fc
        tbl[0]  = mk(30, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 30, 480, 16'h0000,    0, 0, 2);
        tbl[1]  = mk(30, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 30, 480, 16'h0000,    1, 1, 3);
        tbl[2]  = mk(30, 1,  10,  4, 6'h3F, -1, -1, 6'h00, 0, 30, 480, 16'h801F, 1200, 1, 4);
        tbl[3]  = mk(30, 1,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 30, 480, 16'h0000, 1199, 1, 5);
        tbl[4]  = mk(30, 2,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 30, 480, 16'h0000,  600, 1, 6);
        tbl[5]  = mk(29, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 29, 480, 16'h0000,    0, 0, 7);
        tbl[6]  = mk(30, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 30, 480, 16'h0000,    0, 0, 8);
        tbl[7]  = mk(30, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 0, 30, 480, 16'h0000,    0, 1, 9);
        tbl[8]  = mk(30, 0,  33, 23, 6'h21, -1, -1, 6'h00, 0, 30, 480, 16'h0021,    0, 1, 10);
        tbl[9]  = mk(30, 0,  10,  4, 6'h01, 11,  4, 6'h03, 0, 30, 480, 16'h4000,    0, 1, 11);
        tbl[10] = mk(30, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 1, 30, 480, 16'h0000,    0, 1, 12);
        tail    = mk(30, 0,  -1, -1, 6'h00, -1, -1, 6'h00, 0,  0,   0, 16'h0000,    0, 0, 0);

        rst_n    = 1'b0;
        vga_in   = 8'h88;
        audio_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.frame_done",  32'(frame_done),  32'd0);
        check("reset.locked",      32'(locked),      32'd0);
        check("reset.frame_count", 32'(frame_count), 32'd0);
        check("reset.results",     32'({line_len, hsync_width, frame_lines} | 32'(active_pixels)
                                       | 32'(frame_sig) | 32'(audio_ones)), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) drive(8'h88, 1'b0);

        fork
            begin
                for (int i = 0; i < NV; i++) gen_frame(tbl[i]);
                gen_frame(tail);
            end
            begin
                wait_fd(ok);
                check("startup.fd_seen",     32'(ok),            32'd1);
                check("startup.frame_count", 32'(frame_count),   32'd1);
                check("startup.frame_lines", 32'(frame_lines),   32'd0);
                check("startup.locked",      32'(locked),        32'd0);
                check("startup.line_len",    32'(line_len),      32'd0);
                check("startup.apix",        32'(active_pixels), 32'd0);
                for (int i = 0; i < NV; i++) begin
                    wait_fd(ok);
                    check($sformatf("v%0d.fd_seen", i), 32'(ok), 32'd1);
                    check_report($sformatf("v%0d", i), tbl[i]);
                end
            end
        join

        // Hsync loss: lock holds well short of saturation, drops once hcnt hits 2047
        fd_seen = 0;
        for (int c = 0; c < 1000; c++) begin
            drive(8'h88, 1'b0);
            if (frame_done) fd_seen++;
        end
        @(negedge clk);
        check("hloss.locked_early", 32'(locked), 32'd1);
        for (int c = 0; c < 1100; c++) begin
            drive(8'h88, 1'b0);
            if (frame_done) fd_seen++;
        end
        @(negedge clk);
        check("hloss.locked_late", 32'(locked), 32'd0);
        check("hloss.no_fd",       32'(fd_seen), 32'd0);

        // Mid-frame reset with audio high: everything clears asynchronously
        for (int t = 0; t < 300; t++) begin
            drive(encode((((t + XV) % LINE) >= HSW), !(t < 2 * LINE), 6'h00), 1'b1);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst.frame_count", 32'(frame_count), 32'd0);
        check("rst.audio_ones",  32'(audio_ones),  32'd0);
        check("rst.frame_lines", 32'(frame_lines), 32'd0);
        check("rst.line_len",    32'(line_len),    32'd0);
        check("rst.hsync_width", 32'(hsync_width), 32'd0);
        check("rst.apix",        32'(active_pixels), 32'd0);
        check("rst.locked",      32'(locked),      32'd0);
        vga_in   = 8'h88;
        audio_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fd_seen = 0;
        for (int c = 0; c < 20; c++) begin
            drive(8'h88, 1'b0);
            if (frame_done) fd_seen++;
        end
        check("rst.no_fd_idle", 32'(fd_seen), 32'd0);

        // Lone vfall: frame_done exactly at N+2, one cycle wide
        drive(8'h80, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst.fd_n1", 32'(frame_done), 32'd0);
        @(negedge clk);
        check("rst.fd_n2",        32'(frame_done),  32'd1);
        check("rst.fc_restart",   32'(frame_count), 32'd1);
        check("rst.lines_after",  32'(frame_lines), 32'd0);
        check("rst.audio_after",  32'(audio_ones),  32'd0);
        @(negedge clk);
        check("rst.fd_n3", 32'(frame_done), 32'd0);

        // Simultaneous hfall+vfall leaves vcnt at 0; the next hfall makes it 1
        drive(8'h88, 1'b0);
        drive(8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("simul.fd",    32'(frame_done),  32'd1);
        check("simul.fc",    32'(frame_count), 32'd2);
        check("simul.lines", 32'(frame_lines), 32'd0);
        repeat (3) drive(8'h88, 1'b0);
        repeat (2) drive(8'h08, 1'b0);
        repeat (3) drive(8'h88, 1'b0);
        drive(8'h80, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("simul2.fd",          32'(frame_done),  32'd1);
        check("simul2.fc",          32'(frame_count), 32'd3);
        check("simul2.lines",       32'(frame_lines), 32'd1);
        check("simul2.line_len",    32'(line_len),    32'd6);
        check("simul2.hsync_width", 32'(hsync_width), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
